// File: rtl/sipo_rx_ctrl.sv
// Serial-frame receiver: start bit, WIDTH data bits MSB-first, optional even parity, stop bit.
// Latency: the word and its error flags appear the cycle after the edge that samples the stop bit.
// Backpressure: pout_valid/pout_ready handshake. A frame that completes while a word is still pending is dropped and sets sticky overrun.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   sin, bit_en        serial line and bit strobe; sin is only looked at when bit_en=1
//   pout, pout_valid,  received word (first data bit in MSB) and its handshake
//   pout_ready
//   parity_err,        error flags that travel with the word in pout
//   frame_err
//   overrun, clr_err   sticky dropped-frame flag and its synchronous clear
//   busy               a frame is in progress
module sipo_rx_ctrl #(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             bit_en,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             par_pend;
  logic             last_bit;
  logic             start_det, shift_en, par_en, done, load, drop;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; nothing moves without a bit strobe
  always_comb begin
    state_nxt = state;
    if (bit_en) begin
      case (state)
        IDLE:    if (!sin) state_nxt = SHIFT;
        SHIFT: begin
          if (last_bit) begin
            if (PARITY_EN) state_nxt = PARITY;
            else           state_nxt = STOP;
          end
        end
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output / control decode
  always_comb begin
    busy      = (state != IDLE);
    start_det = bit_en && (state == IDLE) && !sin;
    shift_en  = bit_en && (state == SHIFT);
    par_en    = bit_en && (state == PARITY);
    done      = bit_en && (state == STOP);
    // A consume on the completion edge frees the slot for the new word
    load      = done && (!pout_valid || pout_ready);
    drop      = done && pout_valid && !pout_ready;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg      <= '0;
      cnt        <= '0;
      par_pend   <= 1'b0;
      pout       <= '0;
      pout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (start_det) begin
        cnt      <= '0;
        par_pend <= 1'b0;
      end

      if (shift_en) begin
        shreg <= {shreg[WIDTH-2:0], sin};
        cnt   <= cnt + CW'(1);
      end

      // Even parity: the received bit must equal the XOR of the data bits
      if (par_en) begin
        par_pend <= sin ^ (^shreg);
      end

      if (load) begin
        pout       <= shreg;
        parity_err <= par_pend;
        frame_err  <= !sin;
        pout_valid <= 1'b1;
      end else if (pout_valid && pout_ready) begin
        pout_valid <= 1'b0;
      end

      // Set has priority over clear
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
module tb_sipo_rx_ctrl;

  logic       clk;
  logic       rst;
  logic       sin;
  logic       bit_en;
  logic [3:0] pout;
  logic       pout_valid;
  logic       pout_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       clr_err;
  logic       busy;

  int checks;
  int errors;

  sipo_rx_ctrl #(.WIDTH(4), .PARITY_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .bit_en     (bit_en),
    .pout       (pout),
    .pout_valid (pout_valid),
    .pout_ready (pout_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clr_err    (clr_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge; presents one strobed bit, then gap idle cycles
  task automatic send_bit(input logic b, input int gap);
    sin    = b;
    bit_en = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
    sin    = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // start, 4 data bits MSB first, parity, stop; optional ready on the stop bit
  task automatic send_frame(input logic [3:0] d, input logic par, input logic stp,
                            input int gap, input logic rdy_on_stop);
    send_bit(1'b0, gap);
    for (int i = 3; i >= 0; i--) send_bit(d[i], gap);
    send_bit(par, gap);
    pout_ready = rdy_on_stop;
    send_bit(stp, gap);
    pout_ready = 1'b0;
  endtask

  task automatic consume();
    pout_ready = 1'b1;
    @(negedge clk);
    pout_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sin    = 1'(i);
      bit_en = 1'b1;
      @(negedge clk);
    end
    checks++;
    if ({pout, pout_valid, parity_err, frame_err, overrun, busy} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b",
               {pout, pout_valid, parity_err, frame_err, overrun, busy}, 9'b0);
    end
    rst = 1'b1;
    sin = 1'b1;
    bit_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_busy cycle %0d: got %b want 0", i, busy);
      end
    end
    bit_en = 1'b0;
  endtask

  task automatic test_good_frame();
    send_frame(4'b1010, 1'b0, 1'b1, 0, 1'b0);
    checks++;
    if ({pout, pout_valid, parity_err, frame_err, overrun} !== {4'b1010, 4'b1000}) begin
      errors++;
      $display("FAIL good_frame: got %b want %b",
               {pout, pout_valid, parity_err, frame_err, overrun}, {4'b1010, 4'b1000});
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL good_busy_after: got %b want 0", busy);
    end
    consume();
    checks++;
    if ({pout, pout_valid} !== {4'b1010, 1'b0}) begin
      errors++;
      $display("FAIL good_consume: got %b want %b", {pout, pout_valid}, {4'b1010, 1'b0});
    end
  endtask

  task automatic test_errors();
    send_frame(4'b1110, 1'b0, 1'b0, 0, 1'b0);
    checks++;
    if ({pout, pout_valid, parity_err, frame_err} !== {4'b1110, 3'b111}) begin
      errors++;
      $display("FAIL err_both: got %b want %b",
               {pout, pout_valid, parity_err, frame_err}, {4'b1110, 3'b111});
    end
    consume();
    // 0100 has odd weight, so parity 0 is wrong; stop is good
    send_frame(4'b0100, 1'b0, 1'b1, 0, 1'b0);
    checks++;
    if ({pout, pout_valid, parity_err, frame_err} !== {4'b0100, 3'b110}) begin
      errors++;
      $display("FAIL err_parity_only: got %b want %b",
               {pout, pout_valid, parity_err, frame_err}, {4'b0100, 3'b110});
    end
    consume();
    // 0111 has odd weight, parity 1 is correct
    send_frame(4'b0111, 1'b1, 1'b1, 0, 1'b0);
    checks++;
    if ({pout, pout_valid, parity_err, frame_err} !== {4'b0111, 3'b100}) begin
      errors++;
      $display("FAIL err_none_odd: got %b want %b",
               {pout, pout_valid, parity_err, frame_err}, {4'b0111, 3'b100});
    end
    consume();
  endtask

  task automatic test_overrun();
    send_frame(4'b1010, 1'b0, 1'b1, 0, 1'b0);
    // dropped frame carries a bad parity bit, so leaked flags would show
    send_frame(4'b0110, 1'b1, 1'b1, 0, 1'b0);
    checks++;
    if ({pout, pout_valid, parity_err, frame_err, overrun} !== {4'b1010, 4'b1001}) begin
      errors++;
      $display("FAIL overrun_set: got %b want %b",
               {pout, pout_valid, parity_err, frame_err, overrun}, {4'b1010, 4'b1001});
    end
    @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++;
    if ({overrun, pout_valid, pout} !== {2'b01, 4'b1010}) begin
      errors++;
      $display("FAIL overrun_clear: got %b want %b", {overrun, pout_valid, pout}, {2'b01, 4'b1010});
    end
  endtask

  task automatic test_simultaneous();
    // pout_valid is still 1 holding 1010; consume lands on the completion edge
    send_frame(4'b0011, 1'b0, 1'b1, 0, 1'b1);
    checks++;
    if ({pout, pout_valid, overrun, parity_err, frame_err} !== {4'b0011, 4'b1000}) begin
      errors++;
      $display("FAIL simult_load: got %b want %b",
               {pout, pout_valid, overrun, parity_err, frame_err}, {4'b0011, 4'b1000});
    end
    consume();
  endtask

  task automatic test_gapped();
    send_bit(1'b0, 2);
    send_bit(1'b1, 1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL gap_busy_hold: got %b want 1", busy);
    end
    @(negedge clk);
    send_bit(1'b0, 2);
    send_bit(1'b1, 2);
    send_bit(1'b0, 2);
    send_bit(1'b0, 2);
    send_bit(1'b1, 2);
    checks++;
    if ({pout, pout_valid, parity_err, frame_err} !== {4'b1010, 3'b100}) begin
      errors++;
      $display("FAIL gap_frame: got %b want %b",
               {pout, pout_valid, parity_err, frame_err}, {4'b1010, 3'b100});
    end
    consume();
  endtask

  task automatic test_reset_mid();
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_before: got %b want 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, pout_valid, pout, overrun} !== 7'b0) begin
      errors++;
      $display("FAIL mid_reset_async: got %b want %b", {busy, pout_valid, pout, overrun}, 7'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_frame(4'b0110, 1'b0, 1'b1, 0, 1'b0);
    checks++;
    if ({pout, pout_valid, parity_err, frame_err} !== {4'b0110, 3'b100}) begin
      errors++;
      $display("FAIL mid_after_frame: got %b want %b",
               {pout, pout_valid, parity_err, frame_err}, {4'b0110, 3'b100});
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    sin        = 1'b1;
    bit_en     = 1'b0;
    pout_ready = 1'b0;
    clr_err    = 1'b0;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_errors();
    test_overrun();
    test_simultaneous();
    test_gapped();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_rx_ctrl.md
Name: sipo_rx_ctrl

Overview:
Serial-frame receive controller that sequences a WIDTH-bit serial-in/parallel-out shift datapath.
It detects a start bit, shifts WIDTH data bits MSB-first, optionally checks even parity, and checks the stop bit.
It presents the assembled word on a valid/ready output port with overrun and error reporting.
It sits between a serial line front end that supplies the bit strobe and a parallel consumer.

Parameters:
WIDTH, 4, data bits per frame (2..32)
PARITY_EN, 1, 1 = even-parity bit follows data; 0 = no parity bit

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
sin  input  1  serial data line, idles high
bit_en  input  1  bit strobe; sin sampled only on cycles with bit_en=1
pout  output  WIDTH  received data word, first data bit in MSB
pout_valid  output  1  pout holds an unconsumed word
pout_ready  input  1  consumer accepts pout when pout_valid=1
parity_err  output  1  parity mismatch for the word in pout
frame_err  output  1  stop bit was 0 for the word in pout
overrun  output  1  sticky: a completed frame was dropped
clr_err  input  1  synchronous clear of overrun
busy  output  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, shift register=0, bit count=0, pout=0. pout_valid, parity_err, frame_err, overrun and busy are all 0.
- States: IDLE, SHIFT, PARITY, STOP. All transitions occur only on cycles with bit_en=1. Cycles without bit_en hold all state.
- IDLE: sin=0 -> SHIFT, count=0. sin=1 -> stay in IDLE.
- SHIFT: shreg <= {shreg[WIDTH-2:0], sin} and count++. When count reaches WIDTH-1 and the bit is taken: go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: capture sin as the received parity bit -> STOP.
- Parity check: expected bit = XOR of the WIDTH data bits (even parity). Mismatch sets a pending parity error.
- STOP: sample sin; 0 = pending frame error. Frame completes and the state returns to IDLE. Frames are accepted back-to-back: the next bit_en after STOP may be a new start bit.
- Completion latency: pout, pout_valid, parity_err and frame_err update on the clock edge that samples the stop bit. They are visible in the following cycle.
- Handshake: pout_valid=1 and pout_ready=1 on the same cycle consumes the word; pout_valid clears next edge. pout, parity_err and frame_err hold their values until they are replaced.
- Completion when pout_valid=1 and no consume in the same cycle: new word is dropped. Old pout and its error flags are kept, and overrun is set.
- Completion in the same cycle as a consume: new word is loaded, pout_valid stays 1, overrun is not set.
- clr_err=1 clears overrun next edge. If an overrun event occurs in the same cycle, set wins.
- Errors do not abort the frame. The word is still delivered with its error flags.
- Reset asserted mid-frame: the partial frame is discarded and all outputs return to their reset values immediately.
- pout_ready is ignored while pout_valid=0.

Test Plan:
- Reset: hold rst=0 with arbitrary sin and bit_en -> all outputs 0, busy=0. Release rst; sin=1 and bit_en=1 for 5 cycles -> busy stays 0.
- Good frame (WIDTH=4, PARITY_EN=1), bit_en every cycle, sin sequence 0,1,0,1,0,0,1 (start, data 1010, parity 0, stop) -> pout=4'b1010, pout_valid=1 in the cycle after the stop edge, parity_err=0, frame_err=0.
- Errors: sin sequence 0,1,1,1,0,0,0 (data 1110 needs parity 1; stop is 0) -> pout=4'b1110, parity_err=1, frame_err=1, pout_valid=1.
- Overrun: pout_ready=0, send 1010 then 0110 back-to-back -> pout stays 4'b1010, overrun=1. Pulse clr_err -> overrun=0.
- Simultaneous: pout_ready=1 exactly on the completion edge of a second frame 0011 -> pout=4'b0011, pout_valid stays 1, overrun=0.
- Gapped strobe / reset mid-frame: bit_en every 3rd cycle -> same pout as the continuous case. Drop rst after 2 data bits -> busy=0 immediately; a following full frame is received correctly.
